serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the operand and result width in bits (minimum 2).
REQ-002 The block SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port START  input  1  request to begin a subtraction; sampled on the rising edge of CLK.
REQ-005 The block SHALL have port A  input  WIDTH  minuend; captured only when START is accepted.
REQ-006 The block SHALL have port B  input  WIDTH  subtrahend; captured only when START is accepted.
REQ-007 The block SHALL have port D  output  WIDTH  registered difference A-B modulo 2^WIDTH.
REQ-008 The block SHALL have port BO  output  1  borrow out; 1 when A<B, operands taken as unsigned.
REQ-009 The block SHALL have port V  output  1  signed (two's-complement) overflow of A-B.
REQ-010 The block SHALL have port ZERO  output  1  1 when D==0.
REQ-011 The block SHALL have port BUSY  output  1  1 while a subtraction is in progress.
REQ-012 The block SHALL have port DONE  output  1  one-cycle pulse marking that D/BO/V/ZERO hold a new result.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 In IDLE or DONE with START=1 at a rising edge: capture A and B into internal shift registers, clear the borrow flop and the bit counter, enter SHIFT, and drive BUSY=1 from that edge.
REQ-015 In SHIFT, each rising edge SHALL process one bit, LSB first:
- diff bit = a^b^br
- new br = (~a&b) | (~(a^b)&br)
- shift the diff bit into the MSB of the internal result register
- increment the counter
REQ-016 The WIDTH-th SHIFT edge SHALL atomically load D, BO (the final borrow), V, and ZERO, and SHALL set DONE=1, set BUSY=0, and enter DONE.
REQ-017 Latency SHALL be fixed: with START accepted at edge t0, DONE is high for exactly the cycle following edge t0+WIDTH.
REQ-018 V SHALL equal (A[MSB]!=B[MSB]) && (D[MSB]!=A[MSB]), computed from the captured operands.
REQ-019 In DONE without START, the next edge SHALL enter IDLE and set DONE=0.
REQ-020 In DONE with START=1, the next edge SHALL accept the new operands (back-to-back) and set DONE=0, BUSY=1.
REQ-021 START in SHIFT SHALL be ignored; the in-flight operation and its operands are unaffected.
REQ-022 D, BO, V, and ZERO SHALL hold their last result between completions and SHALL NOT show intermediate shift values.
REQ-023 Changes on A or B after capture SHALL have no effect on the in-flight operation.

Reset
REQ-024 RST=1 SHALL immediately, without waiting for a clock edge, force the FSM to IDLE and clear the counter, borrow, shift registers, D, BO, V, ZERO, BUSY, and DONE to 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation, and no DONE SHALL follow for it.
REQ-026 START coincident with the rising edge at which RST deasserts SHALL be ignored; the first START the block can accept is at the following edge.

Verification (WIDTH=32)
REQ-027 Basic subtraction: A=5, B=3, START for 1 cycle -> after 32 edges D=0x00000002, BO=0, V=0, ZERO=0, DONE pulse of 1 cycle, BUSY high for exactly 32 cycles.
REQ-028 Borrow case: A=3, B=5 -> D=0xFFFFFFFE, BO=1, V=0, ZERO=0.
REQ-029 Signed overflow: A=0x80000000, B=0x00000001 -> D=0x7FFFFFFF, BO=0, V=1; then A=0x7FFFFFFF, B=0xFFFFFFFF -> D=0x80000000, BO=1, V=1.
REQ-030 Zero result: A=B=0x1234ABCD -> D=0, ZERO=1, BO=0, V=0.
REQ-031 Ignored and back-to-back START:
- first operation A=10, B=4
- START with A=1, B=1 during SHIFT -> ignored, result D=6
- START with A=9, B=2 in the DONE cycle -> accepted, D=7 after 32 more edges
REQ-032 Reset mid-operation: RST pulsed 10 cycles into a subtraction, between clock edges -> all outputs 0 immediately, no DONE ever appears; a new START after reset release gives correct results.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned/two's-complement subtractor: computes A-B one bit per clock, LSB first,
// and presents D, BO, V and ZERO together with a one-cycle DONE pulse after WIDTH shift cycles.
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             V,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             bo_q, bo_d;
  logic             v_q, v_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             armed_q, armed_d;

  logic             accept;
  logic             diff_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // armed_q stays low through the first edge after reset release, so a START
  // coincident with that edge is never taken.
  assign accept   = armed_q && START && (state_q != S_SHIFT);
  assign diff_bit = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_next = {diff_bit, r_q[WIDTH-1:1]};

  // NOTE: every variable gets its hold value before the case so no path leaves
  // one unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    bo_d    = bo_q;
    v_d     = v_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    armed_d = 1'b1;

    if (accept) begin
      a_d     = A;
      b_d     = B;
      a_msb_d = A[WIDTH-1];
      b_msb_d = B[WIDTH-1];
      br_d    = 1'b0;
      cnt_d   = '0;
      busy_d  = 1'b1;
      state_d = S_SHIFT;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_SHIFT: begin
          a_d   = a_q >> 1;
          b_d   = b_q >> 1;
          br_d  = br_next;
          r_d   = res_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // The last diff bit lands in the MSB, so it is also D[MSB] for V.
            d_d     = res_next;
            bo_d    = br_next;
            v_d     = (a_msb_q != b_msb_q) && (diff_bit != a_msb_q);
            zero_d  = (res_next == '0);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      bo_q    <= 1'b0;
      v_q     <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      bo_q    <= bo_d;
      v_q     <= v_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      armed_q <= armed_d;
    end
  end

  assign D    = d_q;
  assign BO   = bo_q;
  assign V    = v_q;
  assign ZERO = zero_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=32): directed vector table, hand-written
// multi-cycle sequences, and random operands against an arithmetic reference model.
module tb_serial_subtractor;

  logic        CLK, RST, START;
  logic [31:0] A, B, D;
  logic        BO, V, ZERO, BUSY, DONE;

  int passed = 0;
  int total  = 0;

  serial_subtractor #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
    .D(D), .BO(BO), .V(V), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        bo;
    logic        v;
    logic        zero;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Reference: wide unsigned and signed arithmetic, no bit-serial recurrence.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output logic bo, output logic v, output logic z);
    logic [32:0]        u;
    logic signed [32:0] s;
    u  = {1'b0, a} - {1'b0, b};
    s  = $signed({a[31], a}) - $signed({b[31], b});
    d  = u[31:0];
    bo = u[32];
    v  = (s > 33'sd2147483647) || (s < -33'sd2147483648);
    z  = (d == 32'd0);
  endtask

  // Drives START for one edge, then scrambles A/B to prove they were captured.
  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
    START = 1'b1;
    A     = a;
    B     = b;
    @(negedge CLK);
    START = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  // Entered cyc0 negedges after the accepting edge; returns at the DONE negedge.
  task automatic wait_done(input int cyc0, input logic [31:0] d_before,
                           output int cyc, output int busy);
    logic held;
    held = 1'b1;
    cyc  = cyc0;
    busy = cyc0;
    while (!DONE && cyc < 100) begin
      if (D !== d_before) held = 1'b0;
      @(negedge CLK);
      cyc++;
      if (!DONE && BUSY) busy++;
    end
    check("done_seen", 64'(DONE), 64'(1));
    check("d_held_during_shift", 64'(held), 64'(1));
    check("busy_low_at_done", 64'(BUSY), 64'(0));
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] d, output logic bo, output logic v, output logic z);
    int          cyc, busy;
    logic [31:0] d_before;
    d_before = D;
    pulse_start(a, b);
    check("busy_after_start", 64'(BUSY), 64'(1));
    wait_done(1, d_before, cyc, busy);
    check("latency", 64'(cyc), 64'(33));
    check("busy_cycles", 64'(busy), 64'(32));
    d  = D;
    bo = BO;
    v  = V;
    z  = ZERO;
  endtask

  task automatic check_result(input string tag, input logic [31:0] d, input logic bo,
                              input logic v, input logic z);
    check({tag, "_D"},    64'(D),    64'(d));
    check({tag, "_BO"},   64'(BO),   64'(bo));
    check({tag, "_V"},    64'(V),    64'(v));
    check({tag, "_ZERO"}, 64'(ZERO), 64'(z));
  endtask

  initial begin
    vec_t        vecs[5];
    logic [31:0] gd, md;
    logic        gbo, gv, gz, mbo, mv, mz;
    int          cyc, busy;
    logic        done_seen;

    vecs[0] = '{32'd5,          32'd3,          32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'd3,          32'd5,          32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h8000_0000,  32'h0000_0001,  32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'h1234_ABCD,  32'h1234_ABCD,  32'h0000_0000, 1'b0, 1'b0, 1'b1};

    RST   = 1'b1;
    START = 1'b0;
    A     = '0;
    B     = '0;
    #1;
    check("reset_D", 64'(D), 64'(0));
    check("reset_flags", 64'({BO, V, ZERO, BUSY, DONE}), 64'(0));
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, gd, gbo, gv, gz);
      check("vec_D", 64'(gd), 64'(vecs[i].d));
      check("vec_BO", 64'(gbo), 64'(vecs[i].bo));
      check("vec_V", 64'(gv), 64'(vecs[i].v));
      check("vec_ZERO", 64'(gz), 64'(vecs[i].zero));
      @(negedge CLK);
      check("done_one_cycle", 64'(DONE), 64'(0));
      check("outputs_hold_after_done", 64'(D), 64'(vecs[i].d));
    end

    // Ignored START during SHIFT, then back-to-back START in the DONE cycle.
    pulse_start(32'd10, 32'd4);
    repeat (4) @(negedge CLK);
    START = 1'b1;
    A     = 32'd1;
    B     = 32'd1;
    @(negedge CLK);
    START = 1'b0;
    check("busy_while_ignored", 64'(BUSY), 64'(1));
    wait_done(6, vecs[4].d, cyc, busy);
    check("ignored_latency", 64'(cyc), 64'(33));
    check_result("ignored", 32'd6, 1'b0, 1'b0, 1'b0);
    pulse_start(32'd9, 32'd2);
    check("b2b_done_cleared", 64'(DONE), 64'(0));
    check("b2b_busy", 64'(BUSY), 64'(1));
    wait_done(1, 32'd6, cyc, busy);
    check("b2b_latency", 64'(cyc), 64'(33));
    check_result("b2b", 32'd7, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);

    // Reset mid-operation, asserted between clock edges.
    pulse_start(32'h8000_0000, 32'h0000_0001);
    repeat (9) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("midreset_D", 64'(D), 64'(0));
    check("midreset_flags", 64'({BO, V, ZERO, BUSY, DONE}), 64'(0));
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DONE || BUSY) done_seen = 1'b1;
    end
    check("no_done_after_abort", 64'(done_seen), 64'(0));

    // START held across reset release: the first edge after release must not accept it.
    RST = 1'b1;
    @(negedge CLK);
    START = 1'b1;
    A     = 32'd20;
    B     = 32'd30;
    #4 RST = 1'b0;
    @(negedge CLK);
    check("start_at_release_ignored", 64'(BUSY), 64'(0));
    @(negedge CLK);
    START = 1'b0;
    A     = $urandom;
    B     = $urandom;
    check("start_after_release_taken", 64'(BUSY), 64'(1));
    wait_done(1, 32'd0, cyc, busy);
    check("post_reset_latency", 64'(cyc), 64'(33));
    check_result("post_reset", 32'hFFFF_FFF6, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);

    // Random operands against the reference model.
    for (int i = 0; i < 25; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = ra;
      if (i % 7 == 1) ra = {1'b1, 31'($urandom_range(0, 3))};
      model(ra, rb, md, mbo, mv, mz);
      run_op(ra, rb, gd, gbo, gv, gz);
      check("rand_D", 64'(gd), 64'(md));
      check("rand_BO", 64'(gbo), 64'(mbo));
      check("rand_V", 64'(gv), 64'(mv));
      check("rand_ZERO", 64'(gz), 64'(mz));
      if (i % 2 == 0) @(negedge CLK);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
